// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control unit.
// Covers opcodes, ALU operation classes, sequencer state encoding and decoder output records.
package cpu_pkg;

  localparam logic [2:0] OP_RTYPE   = 3'b000;
  localparam logic [2:0] OP_ADDI    = 3'b001;
  localparam logic [2:0] OP_LW      = 3'b010;
  localparam logic [2:0] OP_SW      = 3'b011;
  localparam logic [2:0] OP_BEQ     = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_ILLEGAL = 3'b110;
  localparam logic [2:0] OP_HALT    = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_MUL   = 2'b11;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_STEP          = 16'h0002;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } cpuState_e;

  // Datapath controls that are held for the whole instruction.
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic [1:0] aluOp;
  } levelCtl_t;

  typedef struct packed {
    levelCtl_t lvl;
    logic      isBranch;
    logic      isLoad;
    logic      isStore;
    logic      isMul;
    logic      isHalt;
    logic      isIllegal;
  } decodeOut_t;

  function automatic logic [2:0] opcodeOf(input logic [15:0] instr);
    return instr[15:13];
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: level controls plus instruction class flags.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  output decodeOut_t dec
);

  // Opcode to control/class mapping; unknown encodings fall into the illegal class.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.lvl.regDst = 1'b1;
        dec.lvl.aluOp  = ALU_FUNCT;
      end
      OP_ADDI: begin
        dec.lvl.aluSrc = 1'b1;
        dec.lvl.aluOp  = ALU_ADD;
      end
      OP_LW: begin
        dec.lvl.aluSrc   = 1'b1;
        dec.lvl.memToReg = 1'b1;
        dec.lvl.aluOp    = ALU_ADD;
        dec.isLoad       = 1'b1;
      end
      OP_SW: begin
        dec.lvl.aluSrc = 1'b1;
        dec.lvl.aluOp  = ALU_ADD;
        dec.isStore    = 1'b1;
      end
      OP_BEQ: begin
        dec.lvl.aluOp = ALU_SUB;
        dec.isBranch  = 1'b1;
      end
      OP_MUL: begin
        dec.lvl.regDst = 1'b1;
        dec.lvl.aluOp  = ALU_MUL;
        dec.isMul      = 1'b1;
      end
      OP_HALT:    dec.isHalt    = 1'b1;
      OP_ILLEGAL: dec.isIllegal = 1'b1;
      default:    dec.isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: owns PC, IR and retire counter, fetches instructions
// and sequences datapath controls through FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [15:0] IMemData,
  output logic [15:0] Instruction,
  output logic [15:0] PC,
  input  logic [15:0] BEQPC,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MulRegWrite,
  output logic [1:0]  ALUOp,
  output logic        Halted,
  output logic        Illegal,
  output logic [15:0] Retired
);

  cpuState_e  state_r;
  logic [15:0] pcReg_r;
  logic [15:0] instrReg_r;
  logic [15:0] retired_r;
  levelCtl_t  levels_r;
  logic       branch_r;
  logic       memRead_r;
  logic       memWrite_r;
  logic       regWrite_r;
  logic       mulRegWrite_r;
  logic       halted_r;
  logic       illegal_r;
  decodeOut_t dec_s;

  cpu_decoder uDecoder (
    .opcode (opcodeOf(instrReg_r)),
    .dec    (dec_s)
  );

  // Sequencer FSM with PC, IR, retire counter and registered controls.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r       <= ST_FETCH;
      pcReg_r       <= RESET_PC;
      instrReg_r    <= 16'h0000;
      retired_r     <= 16'h0000;
      levels_r      <= '0;
      branch_r      <= 1'b0;
      memRead_r     <= 1'b0;
      memWrite_r    <= 1'b0;
      regWrite_r    <= 1'b0;
      mulRegWrite_r <= 1'b0;
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      branch_r      <= 1'b0;
      memRead_r     <= 1'b0;
      memWrite_r    <= 1'b0;
      regWrite_r    <= 1'b0;
      mulRegWrite_r <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (IMemValid) begin
            instrReg_r <= IMemData;
            state_r    <= ST_DECODE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          levels_r <= dec_s.lvl;
          if (dec_s.isHalt) begin
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
          end else if (dec_s.isIllegal) begin
            halted_r  <= 1'b1;
            illegal_r <= 1'b1;
            state_r   <= ST_HALT;
          end else begin
            branch_r <= dec_s.isBranch;
            state_r  <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (dec_s.isBranch) begin
            pcReg_r   <= BEQPC;
            retired_r <= retired_r + 16'd1;
            levels_r  <= '0;
            state_r   <= ST_FETCH;
          end else if (dec_s.isLoad || dec_s.isStore) begin
            memRead_r  <= dec_s.isLoad;
            memWrite_r <= dec_s.isStore;
            state_r    <= ST_MEM;
          end else begin
            regWrite_r    <= ~dec_s.isMul;
            mulRegWrite_r <= dec_s.isMul;
            state_r       <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          if (dec_s.isStore) begin
            pcReg_r   <= pcReg_r + PC_STEP;
            retired_r <= retired_r + 16'd1;
            levels_r  <= '0;
            state_r   <= ST_FETCH;
          end else begin
            memRead_r  <= 1'b1;
            regWrite_r <= 1'b1;
            state_r    <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          pcReg_r   <= pcReg_r + PC_STEP;
          retired_r <= retired_r + 16'd1;
          levels_r  <= '0;
          state_r   <= ST_FETCH;
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Request and write strobes are masked while Reset is high so nothing escapes a reset cycle.
  assign IMemReq     = (state_r == ST_FETCH) && !Reset;
  assign MemWrite    = memWrite_r && !Reset;
  assign RegWrite    = regWrite_r && !Reset;
  assign MulRegWrite = mulRegWrite_r && !Reset;

  assign IMemAddr    = pcReg_r;
  assign PC          = pcReg_r + PC_STEP;
  assign Instruction = instrReg_r;
  assign Retired     = retired_r;
  assign Halted      = halted_r;
  assign Illegal     = illegal_r;
  assign Branch      = branch_r;
  assign MemRead     = memRead_r;
  assign RegDst      = levels_r.regDst;
  assign ALUSrc      = levels_r.aluSrc;
  assign MemToReg    = levels_r.memToReg;
  assign ALUOp       = levels_r.aluOp;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of instructions with per-instruction
// expectations queued at drive time, plus hand sequences for reset and halt corners.
module tb_cpu_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemValid;
  logic [15:0] IMemData;
  logic [15:0] Instruction;
  logic [15:0] PC;
  logic [15:0] BEQPC;
  logic        RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, MulRegWrite;
  logic [1:0]  ALUOp;
  logic        Halted, Illegal;
  logic [15:0] Retired;

  cpu_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData), .Instruction(Instruction), .PC(PC),
    .BEQPC(BEQPC), .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MulRegWrite(MulRegWrite), .ALUOp(ALUOp), .Halted(Halted), .Illegal(Illegal),
    .Retired(Retired)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] addr;
    int          fetchCycles;
    logic [15:0] beqpc;
    int          cycles;
    int          nBranch;
    int          nMemRead;
    int          nMemWrite;
    int          nRegWrite;
    int          nMulWrite;
    logic [1:0]  aluOp;
    logic        regDst;
    logic        aluSrc;
    logic        memToReg;
    logic [15:0] nextAddr;
    logic        halted;
    logic        illegal;
  } vec_t;

  vec_t        table_v[7];
  vec_t        sbQ[$];
  int          nChecks = 0;
  int          nPass   = 0;
  logic [15:0] expRetired;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic zeroCheck(input string tag);
    chk({tag, " controls"}, int'({RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc,
                                  RegWrite, MulRegWrite, ALUOp}), 0);
    chk({tag, " IMemAddr"}, int'(IMemAddr), 0);
    chk({tag, " Instruction"}, int'(Instruction), 0);
    chk({tag, " Retired"}, int'(Retired), 0);
    chk({tag, " Halted/Illegal"}, int'({Halted, Illegal}), 0);
  endtask

  task automatic resetDut();
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("reset IMemReq low", int'(IMemReq), 0);
    zeroCheck("reset");
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("post-reset IMemReq", int'(IMemReq), 1);
    expRetired = 16'h0000;
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the next FETCH or HALT sample.
  task automatic runInstr(input vec_t v);
    vec_t        e;
    int          post = 0;
    bit          done = 1'b0;
    int          nBr = 0, nMr = 0, nMw = 0, nRw = 0, nMul = 0;
    logic [5:0]  decLv = '0;
    logic [4:0]  exLv = '0;
    sbQ.push_back(v);
    chk("fetch addr", int'(IMemAddr), int'(v.addr));
    for (int i = 1; i <= v.fetchCycles; i++) begin
      IMemValid = (i == v.fetchCycles);
      IMemData  = (i == v.fetchCycles) ? v.instr : 16'hE000;
      @(posedge Clock);
      @(negedge Clock);
    end
    IMemValid = 1'b0;
    BEQPC     = v.beqpc;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) decLv = {RegDst, ALUSrc, MemToReg, ALUOp, IMemReq};
      if (k == 2) exLv = {RegDst, ALUSrc, MemToReg, ALUOp};
      if (IMemReq || Halted) begin
        done = 1'b1;
        post = k - 1;
        break;
      end
      nBr += int'(Branch);
      nMr += int'(MemRead);
      nMw += int'(MemWrite);
      nRw += int'(RegWrite);
      nMul += int'(MulRegWrite);
      @(posedge Clock);
      @(negedge Clock);
    end
    e = sbQ.pop_front();
    if (!e.halted) expRetired = expRetired + 16'd1;
    chk("completes in budget", int'(done), 1);
    chk("cycles", v.fetchCycles + post, e.cycles);
    chk("decode levels zero", int'(decLv), 0);
    chk("Branch pulses", nBr, e.nBranch);
    chk("MemRead cycles", nMr, e.nMemRead);
    chk("MemWrite pulses", nMw, e.nMemWrite);
    chk("RegWrite pulses", nRw, e.nRegWrite);
    chk("MulRegWrite pulses", nMul, e.nMulWrite);
    chk("levels {RegDst,ALUSrc,MemToReg,ALUOp}", int'(exLv),
        int'({e.regDst, e.aluSrc, e.memToReg, e.aluOp}));
    chk("next IMemAddr", int'(IMemAddr), int'(e.nextAddr));
    chk("Retired", int'(Retired), int'(expRetired));
    chk("Halted/Illegal", int'({Halted, Illegal}), int'({e.halted, e.illegal}));
  endtask

  initial begin
    int   mw;
    int   reqSeen;
    int   notHalted;
    vec_t h;

    //               instr    addr    fc beqpc    cyc br mr mw rw mu aluOp  rd as mr next      hlt ill
    table_v[0] = '{16'h0520, 16'h0000, 1, 16'h0000, 4, 0, 0, 0, 1, 0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    table_v[1] = '{16'h2245, 16'h0002, 1, 16'h0000, 4, 0, 0, 0, 1, 0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
    table_v[2] = '{16'h4081, 16'h0004, 3, 16'h0000, 7, 0, 2, 0, 1, 0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0006, 1'b0, 1'b0};
    table_v[3] = '{16'h6081, 16'h0006, 2, 16'h0000, 5, 0, 0, 1, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    table_v[4] = '{16'h8042, 16'h0008, 1, 16'h0010, 3, 1, 0, 0, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    table_v[5] = '{16'hA520, 16'h0010, 1, 16'h0000, 4, 0, 0, 0, 0, 1, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    table_v[6] = '{16'h8042, 16'h0012, 1, 16'hFFFE, 3, 1, 0, 0, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0};

    Reset = 1'b1; IMemValid = 1'b0; IMemData = 16'h0000; BEQPC = 16'h0000;
    expRetired = 16'h0000;
    resetDut();

    for (int i = 0; i < 7; i++) runInstr(table_v[i]);

    // Retire counter wrap together with PC wrap at the top of the address space.
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    expRetired = 16'hFFFF;
    h = '{16'h6081, 16'hFFFE, 1, 16'h0000, 4, 0, 0, 1, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    runInstr(h);

    // Reset arriving while an SW sits in MEM must swallow its MemWrite.
    mw = 0;
    IMemValid = 1'b1; IMemData = 16'h6081;
    @(posedge Clock); @(negedge Clock);
    IMemValid = 1'b0;
    mw += int'(MemWrite);
    @(posedge Clock); @(negedge Clock);
    mw += int'(MemWrite);
    @(posedge Clock); #1 Reset = 1'b1;
    @(negedge Clock);
    mw += int'(MemWrite);
    chk("IMemReq low in reset cycle", int'(IMemReq), 0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    mw += int'(MemWrite);
    chk("SW reset MemWrite pulses", mw, 0);
    zeroCheck("mid-MEM reset");
    chk("mid-MEM reset back in FETCH", int'(IMemReq), 1);
    expRetired = 16'h0000;

    // Illegal opcode: stops the core, ignores further fetch data.
    h = '{16'hC000, 16'h0000, 1, 16'h0000, 2, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    runInstr(h);
    reqSeen = 0; notHalted = 0;
    IMemValid = 1'b1; IMemData = 16'h0520;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); @(negedge Clock);
      reqSeen += int'(IMemReq);
      notHalted += int'(!Halted);
    end
    IMemValid = 1'b0;
    chk("halted IMemReq cycles", reqSeen, 0);
    chk("halted stays halted", notHalted, 0);
    chk("halted Instruction held", int'(Instruction), 32'hC000);
    chk("halted Retired unchanged", int'(Retired), int'(expRetired));

    // HALT opcode after a fresh reset: stopped without the illegal flag.
    resetDut();
    h = '{16'hE000, 16'h0000, 1, 16'h0000, 2, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    runInstr(h);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 16-bit single-issue CPU. It owns the program counter, fetches instructions over a simple request/valid port, and decodes the 3-bit opcode. It drives every control input of the datapath (RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, MulRegWrite, ALUOp, Instruction, PC) and consumes the datapath's BEQPC result. It sits between instruction memory and the datapath, one level below the CPU top.

## Interface
- Parameters:
- RESET_PC, 16'h0000, address of the first fetch after reset.
- Ports (Clock single clock; Reset synchronous, active-high):
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous active-high reset.
- IMemReq  out  1  fetch request.
- IMemAddr  out  16  fetch address; equals PCReg.
- IMemValid  in  1  IMemData valid this cycle.
- IMemData  in  16  fetched instruction.
- Instruction  out  16  latched instruction register (IR).
- PC  out  16  PCReg + 2, to datapath branch adder.
- BEQPC  in  16  datapath next-PC candidate.
- RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, MulRegWrite  out  1 each  datapath controls.
- ALUOp  out  2  ALU control class.
- Halted  out  1  core stopped (HALT or illegal opcode).
- Illegal  out  1  stop was caused by an illegal opcode.
- Retired  out  16  count of completed instructions.

## Operation
- Opcode = IR[15:13]: 000 R-type; 001 ADDI; 010 LW; 011 SW; 100 BEQ; 101 MUL; 110 illegal; 111 HALT.
- ALUOp classes: 00 add (ADDI/LW/SW), 01 subtract (BEQ), 10 funct-decoded (R-type), 11 multiply (MUL).
- Level controls (ALUOp, ALUSrc, RegDst, MemToReg):
  - Registered at DECODE exit and held until the instruction completes.
  - Values: ALUSrc=1 for ADDI/LW/SW. RegDst=1 for R-type/MUL. MemToReg=1 for LW.
  - All level controls are 0 in FETCH and DECODE.
- Strobes are asserted only in their own state:
  - Branch in EXECUTE, for BEQ only.
  - MemWrite for exactly one cycle in MEM, for SW.
  - MemRead in MEM and WRITEBACK, for LW.
  - RegWrite for exactly one cycle in WRITEBACK, for R-type/ADDI/LW.
  - MulRegWrite instead of RegWrite, for MUL.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
  - FETCH: IMemReq=1. On IMemValid, IR<=IMemData, go to DECODE. Otherwise stay.
  - DECODE: register the level controls.
    - Opcode 111 -> HALT.
    - Opcode 110 -> HALT with Illegal<=1.
    - Otherwise -> EXECUTE.
  - EXECUTE:
    - BEQ: PCReg<=BEQPC, Retired++, go to FETCH.
    - LW/SW -> MEM.
    - Other opcodes -> WRITEBACK.
  - MEM:
    - SW: PCReg<=PCReg+2, Retired++, go to FETCH.
    - LW -> WRITEBACK.
  - WRITEBACK: PCReg<=PCReg+2, Retired++, go to FETCH.
  - HALT: all strobes 0, IMemReq=0, Halted=1. Only Reset exits.
- PC arithmetic is modulo 2^16. 16'hFFFE+2 wraps to 16'h0000. Retired wraps from 16'hFFFF to 0.
- HALT and illegal instructions do not increment Retired.

## Timing
- Reset, in any state including mid-instruction:
  - Next cycle: PCReg=RESET_PC, IR=0, Retired=0, Halted=0, Illegal=0; every control output, including ALUOp, is 0.
  - State=FETCH.
  - IMemReq is 0 in the reset cycle itself. It is 1 in the first cycle after Reset deasserts.
  - Any pending MemWrite or RegWrite is suppressed.
- IMemValid may rise in the same cycle as IMemReq. Minimum fetch time is 1 cycle.
- IMemValid is ignored outside FETCH.
- Latency with a 1-cycle fetch: BEQ 3 cycles, R-type/ADDI/MUL/SW 4 cycles, LW 5 cycles.
- BEQPC is sampled at the EXECUTE clock edge. PC output is stable from DECODE onward.
- Reset has priority over every FSM transition.

## Structure
- Shared package cpu_pkg holds:
  - the opcode localparams;
  - the ALUOp codes;
  - the FSM state encoding (3-bit);
  - RESET_PC default.
- One sub-module, cpu_decoder: combinational opcode -> {RegDst, ALUSrc, MemToReg, ALUOp, class flags: isBranch, isLoad, isStore, isMul, isHalt, isIllegal}.
- FSM, PC register and counter stay in cpu_sequencer.

## Test plan
- Reset, then R-type 16'h0520 served with immediate IMemValid:
  - IMemAddr=0.
  - RegWrite high exactly 1 cycle, on cycle 4.
  - RegDst=1, ALUOp=10.
  - Next IMemAddr=2, Retired=1.
- LW at PC 4, IMemValid delayed 3 cycles:
  - FETCH lasts 3 cycles.
  - MemRead high 2 cycles, MemToReg=1, RegWrite 1 cycle.
  - Next PC=6.
- BEQ at PC 8 with BEQPC=16'h0010 in EXECUTE:
  - Branch high 1 cycle.
  - Next IMemAddr=16'h0010.
  - Instruction takes 3 cycles.
- Opcode 110: Halted=1, Illegal=1, IMemReq stays 0 for 20 cycles, Retired unchanged.
- Reset asserted during MEM of an SW:
  - MemWrite never pulses.
  - Next cycle: PCReg=0, state FETCH, all outputs 0.
- SW at PC 16'hFFFE: next IMemAddr=16'h0000. Preload Retired to 16'hFFFF, then retire one instruction: Retired=0.
